input_port_buffer: RTL and testbench
====================================

INPUT_PORT_BUFFER -- requirements
Module: input_port_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, flit slots; power of two, 2..64.
REQ-002 SHALL have parameter ADDR_W, default 2, equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-low (0 = reset).
REQ-005 SHALL have port in_valid, input, 1, link side offers a flit.
REQ-006 SHALL have port in_data, input, 128, offered flit; [63:32] DEST_IP, [31:0] SRC_IP, each IP X in [31:16] and Y in [15:0].
REQ-007 SHALL have port in_ready, output, 1, buffer accepts a flit this cycle.
REQ-008 SHALL have port have_data, output, 1, head flit is available to the switch.
REQ-009 SHALL have port data_out, output, 128, head flit toward the switch.
REQ-010 SHALL have port dst_x, output, 16, head flit bits [63:48].
REQ-011 SHALL have port dst_y, output, 16, head flit bits [47:32].
REQ-012 SHALL have port read_enable, input, 1, switch pops the head flit.
REQ-013 SHALL have port count, output, ADDR_W+1, current occupancy.

Function
REQ-014 SHALL store flits in a circular buffer of DEPTH x 128 with write pointer, read pointer (ADDR_W bits, wrapping DEPTH-1 -> 0) and occupancy counter.
REQ-015 SHALL drive in_ready = (count != DEPTH), combinationally from registered count.
REQ-016 SHALL push in_data on a rising edge where in_valid && in_ready; in_data ignored when in_valid = 0.
REQ-017 SHALL drive have_data = (count != 0); first-word-fall-through: flit pushed at edge N appears on data_out/dst_x/dst_y with have_data = 1 after edge N (latency 1 cycle, empty buffer).
REQ-018 SHALL pop on a rising edge where read_enable && have_data; read_enable while empty SHALL be ignored (no pointer/count change).
REQ-019 SHALL drive data_out, dst_x, dst_y to 0 while have_data = 0.
REQ-020 SHALL, on simultaneous push and pop, write and read in the same edge with count unchanged; allowed whenever 0 < count < DEPTH.
REQ-021 SHALL, when full, deassert in_ready; a pop in that cycle SHALL NOT allow a push in the same cycle (in_ready reasserts the following cycle).
REQ-022 SHALL, when empty, not bypass: a push and read_enable in the same cycle push only; no pop.
REQ-023 SHALL preserve flit order exactly (FIFO) and flit contents bit-exact.
REQ-024 SHALL keep count in 0..DEPTH at all times; no overflow or underflow possible.

Reset
REQ-025 SHALL, while rst = 0, asynchronously clear pointers and count, giving in_ready = 1, have_data = 0, count = 0, data_out = dst_x = dst_y = 0.
REQ-026 SHALL, on reset mid-operation, discard all stored flits; buffer array contents need not be cleared.
REQ-027 SHALL accept a push on the first rising edge after rst returns to 1.

Configuration
REQ-028 SHALL, with macro INPUT_PORT_STATS_EN defined, add outputs flit_count (16, pushes accepted) and stall_count (16, cycles with in_valid && !in_ready), both saturating at 0xFFFF and cleared by reset.
REQ-029 SHALL, without INPUT_PORT_STATS_EN, omit both ports and their counters; all other behaviour identical.

Verification
REQ-030 SHALL cover: reset, push 0x...0003_0002_0000_0001 -> next cycle have_data = 1, dst_x = 3, dst_y = 2, count = 1.
REQ-031 SHALL cover: DEPTH = 4, 5 back-to-back pushes, no pops -> first 4 accepted, in_ready = 0 at count = 4, 5th held until popped.
REQ-032 SHALL cover: count = 2, push and read_enable same cycle for 10 cycles -> count stays 2, output order matches input order across pointer wrap.
REQ-033 SHALL cover: empty, read_enable = 1 for 3 cycles -> count = 0, pointers unchanged, data_out = 0.
REQ-034 SHALL cover: count = 3, rst pulsed low mid-cycle -> immediately have_data = 0, count = 0, in_ready = 1; next push is the only flit seen.
REQ-035 SHALL cover: INPUT_PORT_STATS_EN defined, full buffer with in_valid = 1 for 4 cycles -> stall_count = 4, flit_count = 4.

Source files
------------

// File: rtl/input_port_buffer_if.sv
// Link/switch handshake bundle for the input port flit buffer.
// master = link + switch side, slave = buffer side.
interface input_port_buffer_if #(
  parameter int ADDR_W = 2
);
  logic          in_valid;
  logic [127:0]  in_data;
  logic          in_ready;
  logic          have_data;
  logic [127:0]  data_out;
  logic [15:0]   dst_x;
  logic [15:0]   dst_y;
  logic          read_enable;
  logic [ADDR_W:0] count;

  modport master (
    output in_valid,
    output in_data,
    output read_enable,
    input  in_ready,
    input  have_data,
    input  data_out,
    input  dst_x,
    input  dst_y,
    input  count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  read_enable,
    output in_ready,
    output have_data,
    output data_out,
    output dst_x,
    output dst_y,
    output count
  );
endinterface

// File: rtl/input_port_buffer.sv
// FWFT circular flit buffer for one router input port.
// Define INPUT_PORT_STATS_EN to add flit_count/stall_count.
module input_port_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic clk,
  input  logic rst,
  input_port_buffer_if.slave bus
`ifdef INPUT_PORT_STATS_EN
  ,
  output logic [15:0] flit_count,
  output logic [15:0] stall_count
`endif
);

  typedef logic [ADDR_W:0]   cnt_t;
  typedef logic [ADDR_W-1:0] ptr_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  logic [127:0] mem [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;

  logic ready;
  logic avail;
  logic push;
  logic pop;

  assign ready = (count_q != FULL);
  assign avail = (count_q != '0);
  assign push  = bus.in_valid && ready;
  assign pop   = bus.read_enable && avail;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    unique case (1'b1)
      push && !pop: count_d = count_q + cnt_t'(1);
      pop && !push: count_d = count_q - cnt_t'(1);
      default:      count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; stale slots are never visible past count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.in_data;
  end

  logic [127:0] head;
  assign head = avail ? mem[rd_ptr_q] : '0;

  assign bus.in_ready  = ready;
  assign bus.have_data = avail;
  assign bus.data_out  = head;
  assign bus.dst_x     = head[63:48];
  assign bus.dst_y     = head[47:32];
  assign bus.count     = count_q;

`ifdef INPUT_PORT_STATS_EN
  logic [15:0] flit_q;
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_q  <= '0;
      stall_q <= '0;
    end else begin
      if (push && flit_q != 16'hFFFF)
        flit_q <= flit_q + 16'd1;
      if (bus.in_valid && !ready && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign flit_count  = flit_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_input_port_buffer.sv
// Randomised self-checking bench for input_port_buffer.
// Reference model is a flit queue plus stats counters.
module tb_input_port_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic clk;
  logic rst_n;

  input_port_buffer_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef INPUT_PORT_STATS_EN
  logic [15:0] flit_count;
  logic [15:0] stall_count;
`endif

  input_port_buffer #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
`ifdef INPUT_PORT_STATS_EN
    ,
    .flit_count (flit_count),
    .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [127:0] q[$];
  int flit_exp  = 0;
  int stall_exp = 0;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] exp_head();
    if (q.size() == 0) return '0;
    return q[0];
  endfunction

  // Apply inputs for one clock edge; model follows the spec rules.
  task automatic step(input bit v, input logic [127:0] d,
                      input bit re);
    bit push;
    bit pop;
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.read_enable = re;
    push = v && (q.size() != DEPTH);
    pop  = re && (q.size() != 0);
    if (v && !push && stall_exp < 65535) stall_exp++;
    if (push && flit_exp < 65535) flit_exp++;
    @(posedge clk);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(d);
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.read_enable = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    flit_exp  = 0;
    stall_exp = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    total += 4;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready got=%b exp=1", bus.in_ready);
    end
    if (bus.have_data !== 1'b0) begin
      bad++;
      $display("FAIL rst_have got=%b exp=0", bus.have_data);
    end
    if (bus.count !== '0) begin
      bad++;
      $display("FAIL rst_count got=%0d exp=0", bus.count);
    end
    if (bus.data_out !== '0) begin
      bad++;
      $display("FAIL rst_data got=%h exp=0", bus.data_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_push();
    logic [127:0] f;
    f = {64'h0, 32'h0003_0002, 32'h0000_0001};
    step(1'b1, f, 1'b0);
    total += 5;
    if (bus.have_data !== 1'b1) begin
      bad++;
      $display("FAIL fp_have got=%b exp=1", bus.have_data);
    end
    if (bus.dst_x !== 16'd3) begin
      bad++;
      $display("FAIL fp_dstx got=%0d exp=3", bus.dst_x);
    end
    if (bus.dst_y !== 16'd2) begin
      bad++;
      $display("FAIL fp_dsty got=%0d exp=2", bus.dst_y);
    end
    if (bus.count !== 3'd1) begin
      bad++;
      $display("FAIL fp_count got=%0d exp=1", bus.count);
    end
    if (bus.data_out !== f) begin
      bad++;
      $display("FAIL fp_data got=%h exp=%h", bus.data_out, f);
    end
    step(1'b0, '0, 1'b1);
    total++;
    if (bus.count !== 3'd0 || bus.data_out !== '0) begin
      bad++;
      $display("FAIL fp_pop got=%0d/%h exp=0/0",
               bus.count, bus.data_out);
    end
  endtask

  task automatic test_fill_overflow();
    logic [127:0] f [5];
    for (int i = 0; i < 5; i++) f[i] = rnd128();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, f[i], 1'b0);
      total++;
      if (int'(bus.count) != q.size()) begin
        bad++;
        $display("FAIL fill_count[%0d] got=%0d exp=%0d",
                 i, bus.count, q.size());
      end
    end
    total += 2;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL fill_ready got=%b exp=0", bus.in_ready);
    end
    if (bus.count !== 3'd4) begin
      bad++;
      $display("FAIL fill_full got=%0d exp=4", bus.count);
    end
    // pop while full: 5th flit still held back this edge
    step(1'b1, f[4], 1'b1);
    total++;
    if (bus.count !== 3'd3 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_pop got=%0d/%b exp=3/1",
               bus.count, bus.in_ready);
    end
    step(1'b1, f[4], 1'b0);
    total++;
    if (bus.count !== 3'd4) begin
      bad++;
      $display("FAIL late_push got=%0d exp=4", bus.count);
    end
    for (int i = 1; i < 5; i++) begin
      total++;
      if (bus.data_out !== f[i]) begin
        bad++;
        $display("FAIL fill_order[%0d] got=%h exp=%h",
                 i, bus.data_out, f[i]);
      end
      step(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_push_pop_wrap();
    step(1'b1, rnd128(), 1'b0);
    step(1'b1, rnd128(), 1'b0);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bus.data_out !== exp_head()) begin
        bad++;
        $display("FAIL wrap_data[%0d] got=%h exp=%h",
                 i, bus.data_out, exp_head());
      end
      step(1'b1, rnd128(), 1'b1);
      total++;
      if (bus.count !== 3'd2) begin
        bad++;
        $display("FAIL wrap_count[%0d] got=%0d exp=2",
                 i, bus.count);
      end
    end
    while (q.size() != 0) begin
      total++;
      if (bus.data_out !== exp_head()) begin
        bad++;
        $display("FAIL wrap_drain got=%h exp=%h",
                 bus.data_out, exp_head());
      end
      step(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_empty_read();
    logic [127:0] f;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1);
      total++;
      if (bus.count !== '0 || bus.data_out !== '0 ||
          bus.have_data !== 1'b0) begin
        bad++;
        $display("FAIL empty_rd[%0d] got=%0d/%h exp=0/0",
                 i, bus.count, bus.data_out);
      end
    end
    // empty push + read: push only, no bypass
    f = rnd128();
    step(1'b1, f, 1'b1);
    total++;
    if (bus.count !== 3'd1 || bus.data_out !== f) begin
      bad++;
      $display("FAIL no_bypass got=%0d/%h exp=1/%h",
               bus.count, bus.data_out, f);
    end
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [127:0] f;
    for (int i = 0; i < 3; i++) step(1'b1, rnd128(), 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total += 3;
    if (bus.have_data !== 1'b0) begin
      bad++;
      $display("FAIL mid_have got=%b exp=0", bus.have_data);
    end
    if (bus.count !== '0) begin
      bad++;
      $display("FAIL mid_count got=%0d exp=0", bus.count);
    end
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_ready got=%b exp=1", bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    f = rnd128();
    step(1'b1, f, 1'b0);
    total++;
    if (bus.count !== 3'd1 || bus.data_out !== f) begin
      bad++;
      $display("FAIL mid_only got=%0d/%h exp=1/%h",
               bus.count, bus.data_out, f);
    end
    step(1'b0, '0, 1'b1);
    total++;
    if (bus.have_data !== 1'b0) begin
      bad++;
      $display("FAIL mid_drain got=%b exp=0", bus.have_data);
    end
  endtask

  task automatic test_random();
    logic [127:0] h;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rnd128(),
           $urandom_range(0, 2) != 0);
      h = exp_head();
      total++;
      if (int'(bus.count) != q.size() ||
          bus.in_ready !== (q.size() != DEPTH) ||
          bus.have_data !== (q.size() != 0) ||
          bus.data_out !== h ||
          bus.dst_x !== h[63:48] ||
          bus.dst_y !== h[47:32]) begin
        bad++;
        $display("FAIL rand[%0d] got=%0d/%b/%b/%h exp=%0d/%h",
                 i, bus.count, bus.in_ready, bus.have_data,
                 bus.data_out, q.size(), h);
      end
    end
  endtask

`ifdef INPUT_PORT_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, rnd128(), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, rnd128(), 1'b0);
    total += 2;
    if (int'(stall_count) != stall_exp || stall_exp != 4) begin
      bad++;
      $display("FAIL stall_cnt got=%0d exp=%0d",
               stall_count, stall_exp);
    end
    if (int'(flit_count) != flit_exp || flit_exp != 4) begin
      bad++;
      $display("FAIL flit_cnt got=%0d exp=%0d",
               flit_count, flit_exp);
    end
  endtask
`endif

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.read_enable = 1'b0;
    rst_n           = 1'b0;
    test_reset();
    test_first_push();
    test_fill_overflow();
    test_push_pop_wrap();
    test_empty_read();
    test_reset_mid();
    test_random();
`ifdef INPUT_PORT_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
